// File: rtl/uart_tx_serializer_pkg.sv
// Shared types and line levels for the UART transmit serializer.
// Frame layout is 8N1: one start bit, eight data bits LSB first, one stop bit.
package uart_tx_serializer_pkg;

    localparam int DATA_W     = 8;
    localparam int FRAME_BITS = 10;
    localparam int DATA_BITS  = FRAME_BITS - 2;

    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;
    localparam logic IDLE_LEVEL  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/uart_tx_serializer_if.sv
// Byte-wide valid/ready handshake into the UART transmit serializer.
interface uart_tx_serializer_if;
    import uart_tx_serializer_pkg::*;

    logic [DATA_W-1:0] TX_DATA;
    logic              TX_VALID;
    logic              TX_READY;

    modport master (output TX_DATA, output TX_VALID, input TX_READY);
    modport slave  (input TX_DATA, input TX_VALID, output TX_READY);

endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO with full/empty protection; pointers and count reset
// asynchronously, storage is left uninitialised.
module uart_tx_fifo
    import uart_tx_serializer_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_data,
    output logic [ADDR_W:0]   o_count,
    output logic              o_full,
    output logic              o_empty
);
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(FIFO_DEPTH);

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              w_push;
    logic              w_pop;

    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];
    // A full FIFO refuses a push even when a pop happens on the same edge.
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (ADDR_W+1)'(1);
                2'b01:   r_count <= r_count - (ADDR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// Buffers bytes from a valid/ready port and emits them as 8N1 UART frames on TXD,
// chaining frames back to back whenever the FIFO still holds data at stop-bit end.
module uart_tx_serializer
    import uart_tx_serializer_pkg::*;
#(
    parameter int BAUD_DIV   = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 2
) (
    input  logic                 CLK,
    input  logic                 RESETn,
    uart_tx_serializer_if.slave  tx_if,
    output logic                 TXD,
    output logic                 BUSY,
    output logic [ADDR_W:0]      FIFO_COUNT
);
    localparam int               CNT_W       = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] BAUD_RELOAD = CNT_W'(BAUD_DIV - 1);
    localparam logic [2:0]       LAST_BIT    = 3'(DATA_BITS - 1);

    tx_state_t         r_state;
    logic              r_txd;
    logic [CNT_W-1:0]  r_baud;
    logic [2:0]        r_bit_idx;
    logic [DATA_W-1:0] r_shift;

    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic              w_bit_end;
    logic [DATA_W-1:0] w_rd_data;

    assign w_bit_end = (r_baud == '0);
    // Load from IDLE, or straight from the last stop-bit cycle so frames abut.
    assign w_pop     = ~w_empty & ((r_state == ST_IDLE) | ((r_state == ST_STOP) & w_bit_end));

    uart_tx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .ADDR_W     (ADDR_W)
    ) u_fifo (
        .i_clk   (CLK),
        .i_rst_n (RESETn),
        .i_push  (tx_if.TX_VALID),
        .i_data  (tx_if.TX_DATA),
        .i_pop   (w_pop),
        .o_data  (w_rd_data),
        .o_count (FIFO_COUNT),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign tx_if.TX_READY = ~w_full;
    assign TXD            = r_txd;
    assign BUSY           = (r_state != ST_IDLE) | ~w_empty;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_state   <= ST_IDLE;
            r_txd     <= IDLE_LEVEL;
            r_baud    <= '0;
            r_bit_idx <= '0;
        end else if (w_pop) begin
            r_state <= ST_START;
            r_txd   <= START_LEVEL;
            r_baud  <= BAUD_RELOAD;
        end else begin
            case (r_state)
                ST_IDLE: r_txd <= IDLE_LEVEL;
                ST_START: begin
                    if (w_bit_end) begin
                        r_state   <= ST_DATA;
                        r_bit_idx <= '0;
                        r_txd     <= r_shift[0];
                        r_baud    <= BAUD_RELOAD;
                    end else begin
                        r_baud <= r_baud - CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (w_bit_end) begin
                        r_baud <= BAUD_RELOAD;
                        if (r_bit_idx == LAST_BIT) begin
                            r_state <= ST_STOP;
                            r_txd   <= STOP_LEVEL;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_txd     <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud - CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (w_bit_end) begin
                        r_state <= ST_IDLE;
                        r_txd   <= IDLE_LEVEL;
                    end else begin
                        r_baud <= r_baud - CNT_W'(1);
                    end
                end
            endcase
        end
    end

    // Shifter holds data only; it is reloaded before every frame.
    always_ff @(posedge CLK) begin
        if (w_pop)
            r_shift <= w_rd_data;
        else if ((r_state == ST_DATA) && w_bit_end)
            r_shift <= r_shift >> 1;
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: two instances (BAUD_DIV=1 and 16) share clock and reset;
// TXD is recorded per cycle and compared with frames built from the pushed bytes.
module tb_uart_tx_serializer;

    logic       clk;
    logic       RESETn;
    logic       txd1, busy1, txd16, busy16;
    logic [2:0] cnt1, cnt16;

    uart_tx_serializer_if if1();
    uart_tx_serializer_if if16();

    uart_tx_serializer #(.BAUD_DIV(1), .FIFO_DEPTH(4), .ADDR_W(2)) u_dut1 (
        .CLK(clk), .RESETn(RESETn), .tx_if(if1.slave),
        .TXD(txd1), .BUSY(busy1), .FIFO_COUNT(cnt1)
    );

    uart_tx_serializer #(.BAUD_DIV(16), .FIFO_DEPTH(4), .ADDR_W(2)) u_dut16 (
        .CLK(clk), .RESETn(RESETn), .tx_if(if16.slave),
        .TXD(txd16), .BUSY(busy16), .FIFO_COUNT(cnt16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_fail;

    bit         rec_txd[$];
    bit         rec_busy[$];
    bit         rec_rdy[$];
    int         rec_cnt[$];
    int         first_push;
    bit         timed_out;
    logic [7:0] dec_bytes[$];
    int         dec_ferr;

    // Drive bytes as fast as TX_READY (and optional random gaps) allow, recording every cycle.
    task automatic run_stream(input bit sel16, input logic [7:0] bytes[$], input bit rand_gaps,
                              input int budget);
        logic [7:0] pend[$];
        bit         v;
        bit         rdy;
        bit         busy;
        int         k;
        pend = bytes;
        rec_txd.delete(); rec_busy.delete(); rec_rdy.delete(); rec_cnt.delete();
        first_push = -1;
        timed_out  = 1'b0;
        k = 0;
        forever begin
            @(negedge clk);
            busy = sel16 ? busy16 : busy1;
            rdy  = sel16 ? if16.TX_READY : if1.TX_READY;
            rec_txd.push_back(sel16 ? txd16 : txd1);
            rec_busy.push_back(busy);
            rec_rdy.push_back(rdy);
            rec_cnt.push_back(sel16 ? int'(cnt16) : int'(cnt1));
            if (pend.size() == 0 && !busy) break;
            if (k >= budget) begin
                timed_out = 1'b1;
                break;
            end
            v = (pend.size() > 0) && !(rand_gaps && $urandom_range(2) == 0);
            if1.TX_VALID  = v && !sel16;
            if16.TX_VALID = v && sel16;
            if1.TX_DATA   = v ? pend[0] : 8'($urandom);
            if16.TX_DATA  = if1.TX_DATA;
            if (v && rdy) begin
                if (first_push < 0) first_push = k + 1;
                void'(pend.pop_front());
            end
            k++;
        end
        if1.TX_VALID  = 1'b0;
        if16.TX_VALID = 1'b0;
    endtask

    function automatic int find_start();
        for (int i = 0; i < rec_txd.size(); i++)
            if (rec_txd[i] == 1'b0) return i;
        return -1;
    endfunction

    // Reference line: each byte becomes start(0), data LSB first, stop(1), each bit held bd cycles.
    function automatic int stream_errors(input logic [7:0] exp[$], input int bd, input int s);
        int errs;
        int fl;
        errs = 0;
        fl   = 10 * bd;
        if (s < 0) return exp.size() * fl;
        for (int p = 0; p < exp.size() * fl; p++) begin
            int f;
            int pos;
            bit e;
            f   = p / fl;
            pos = (p % fl) / bd;
            if (pos == 0)      e = 1'b0;
            else if (pos == 9) e = 1'b1;
            else               e = exp[f][pos-1];
            if (s + p >= rec_txd.size()) errs++;
            else if (rec_txd[s+p] !== e) errs++;
        end
        return errs;
    endfunction

    // Capture-style receiver: finds start bits, samples mid-bit, flags bad stop bits.
    function automatic void decode(input int bd);
        int i;
        logic [7:0] b;
        dec_bytes.delete();
        dec_ferr = 0;
        i = 0;
        while (i < rec_txd.size()) begin
            if (rec_txd[i] == 1'b0) begin
                if (i + 10 * bd > rec_txd.size()) begin
                    dec_ferr++;
                    break;
                end
                for (int j = 0; j < 8; j++) b[j] = rec_txd[i + (j + 1) * bd + bd / 2];
                if (rec_txd[i + 9 * bd + bd / 2] != 1'b1) dec_ferr++;
                dec_bytes.push_back(b);
                i += 10 * bd;
            end else begin
                i++;
            end
        end
    endfunction

    task automatic test_reset;
        n_checks++; if (txd1 !== 1'b1) begin n_fail++; $display("FAIL reset_txd1: got %b want 1", txd1); end
        n_checks++; if (if1.TX_READY !== 1'b1) begin n_fail++; $display("FAIL reset_rdy1: got %b want 1", if1.TX_READY); end
        n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL reset_busy1: got %b want 0", busy1); end
        n_checks++; if (cnt1 !== 3'd0) begin n_fail++; $display("FAIL reset_cnt1: got %0d want 0", cnt1); end
        n_checks++; if (txd16 !== 1'b1) begin n_fail++; $display("FAIL reset_txd16: got %b want 1", txd16); end
        n_checks++; if (if16.TX_READY !== 1'b1) begin n_fail++; $display("FAIL reset_rdy16: got %b want 1", if16.TX_READY); end
        n_checks++; if (busy16 !== 1'b0) begin n_fail++; $display("FAIL reset_busy16: got %b want 0", busy16); end
        n_checks++; if (cnt16 !== 3'd0) begin n_fail++; $display("FAIL reset_cnt16: got %0d want 0", cnt16); end
    endtask

    task automatic test_single_byte;
        logic [7:0] exp[$];
        logic [9:0] seq;
        int s;
        exp = '{8'h41};
        run_stream(1'b0, exp, 1'b0, 200);
        n_checks++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL single_timeout: got %b want 0", timed_out); end
        s = find_start();
        n_checks++; if (s !== first_push + 1) begin n_fail++; $display("FAIL single_latency: start at %0d want %0d", s, first_push + 1); end
        seq = '0;
        for (int i = 0; i < 10; i++) if (s >= 0 && s + i < rec_txd.size()) seq[i] = rec_txd[s+i];
        n_checks++; if (seq !== 10'h282) begin n_fail++; $display("FAIL single_bits: got %b want %b", seq, 10'h282); end
        n_checks++;
        if (s < 0 || s + 10 >= rec_busy.size() || rec_busy[s+10] !== 1'b0 || rec_busy[s+9] !== 1'b1) begin
            n_fail++; $display("FAIL single_busy_end: samples=%0d start=%0d want busy 1->0 at %0d", rec_busy.size(), s, s + 10);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp[$];
        int s;
        int errs;
        exp = '{8'h48, 8'h69, 8'h0D, 8'h04};
        run_stream(1'b0, exp, 1'b0, 300);
        n_checks++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL b2b_timeout: got %b want 0", timed_out); end
        s = find_start();
        errs = stream_errors(exp, 1, s);
        n_checks++; if (errs !== 0) begin n_fail++; $display("FAIL b2b_stream: got %0d bad bits want 0", errs); end
        n_checks++; if (rec_txd.size() - 1 !== s + 40) begin n_fail++; $display("FAIL b2b_length: idle at %0d want %0d", rec_txd.size() - 1, s + 40); end
    endtask

    task automatic test_random_stream;
        logic [7:0] exp[$];
        int bad;
        for (int i = 0; i < 10; i++) exp.push_back(8'($urandom));
        run_stream(1'b0, exp, 1'b1, 600);
        n_checks++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL rand_timeout: got %b want 0", timed_out); end
        decode(1);
        n_checks++; if (dec_ferr !== 0) begin n_fail++; $display("FAIL rand_framing: got %0d errors want 0", dec_ferr); end
        n_checks++; if (dec_bytes.size() !== 10) begin n_fail++; $display("FAIL rand_count: got %0d bytes want 10", dec_bytes.size()); end
        bad = 0;
        for (int i = 0; i < 10; i++) if (i >= dec_bytes.size() || dec_bytes[i] !== exp[i]) bad++;
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL rand_order: got %0d wrong bytes want 0", bad); end
    endtask

    task automatic test_full_fifo;
        logic [7:0] exp[$];
        int s;
        int errs;
        int max_cnt;
        int rdy_bad;
        bit saw_full;
        for (int i = 0; i < 6; i++) exp.push_back(8'($urandom));
        run_stream(1'b0, exp, 1'b0, 300);
        n_checks++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL full_timeout: got %b want 0", timed_out); end
        s = find_start();
        errs = stream_errors(exp, 1, s);
        n_checks++; if (errs !== 0) begin n_fail++; $display("FAIL full_stream: got %0d bad bits want 0", errs); end
        max_cnt = 0; rdy_bad = 0; saw_full = 1'b0;
        for (int i = 0; i < rec_cnt.size(); i++) begin
            if (rec_cnt[i] > max_cnt) max_cnt = rec_cnt[i];
            if (rec_rdy[i] !== (rec_cnt[i] < 4)) rdy_bad++;
            if (rec_cnt[i] == 4 && rec_rdy[i] == 1'b0) saw_full = 1'b1;
        end
        n_checks++; if (max_cnt !== 4) begin n_fail++; $display("FAIL full_max_count: got %0d want 4", max_cnt); end
        n_checks++; if (rdy_bad !== 0) begin n_fail++; $display("FAIL full_ready: got %0d bad cycles want 0", rdy_bad); end
        n_checks++; if (saw_full !== 1'b1) begin n_fail++; $display("FAIL full_blocked: got %b want 1", saw_full); end
    endtask

    task automatic test_divided_baud;
        logic [7:0] exp[$];
        int s;
        int errs;
        exp = '{8'h55};
        run_stream(1'b1, exp, 1'b0, 400);
        n_checks++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL div_timeout: got %b want 0", timed_out); end
        s = find_start();
        n_checks++; if (s !== first_push + 1) begin n_fail++; $display("FAIL div_latency: start at %0d want %0d", s, first_push + 1); end
        errs = stream_errors(exp, 16, s);
        n_checks++; if (errs !== 0) begin n_fail++; $display("FAIL div_stream: got %0d bad samples want 0", errs); end
        n_checks++; if (rec_txd.size() - 1 !== s + 160) begin n_fail++; $display("FAIL div_length: idle at %0d want %0d", rec_txd.size() - 1, s + 160); end
        n_checks++;
        if (s < 0 || s + 159 >= rec_busy.size() || rec_busy[s+159] !== 1'b1) begin
            n_fail++; $display("FAIL div_busy_hold: busy not held through stop bit, start=%0d", s);
        end
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0] b[3];
        int txd_low;
        int busy_hi;
        b[0] = 8'($urandom) & 8'hF7;
        b[1] = 8'($urandom);
        b[2] = 8'($urandom);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if1.TX_VALID = 1'b1;
            if1.TX_DATA  = b[i];
        end
        @(negedge clk);
        if1.TX_VALID = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (txd1 !== 1'b0) begin n_fail++; $display("FAIL rst_bit3: got %b want 0", txd1); end
        n_checks++; if (cnt1 !== 3'd2) begin n_fail++; $display("FAIL rst_queued: got %0d want 2", cnt1); end
        #2 RESETn = 1'b0;
        #1;
        n_checks++; if (txd1 !== 1'b1) begin n_fail++; $display("FAIL rst_async_txd: got %b want 1", txd1); end
        n_checks++; if (cnt1 !== 3'd0) begin n_fail++; $display("FAIL rst_async_cnt: got %0d want 0", cnt1); end
        n_checks++; if (if1.TX_READY !== 1'b1) begin n_fail++; $display("FAIL rst_async_rdy: got %b want 1", if1.TX_READY); end
        repeat (2) @(negedge clk);
        RESETn = 1'b1;
        txd_low = 0; busy_hi = 0;
        repeat (30) begin
            @(negedge clk);
            if (txd1 !== 1'b1) txd_low++;
            if (busy1 !== 1'b0) busy_hi++;
        end
        n_checks++; if (txd_low !== 0) begin n_fail++; $display("FAIL rst_no_resume_txd: got %0d low cycles want 0", txd_low); end
        n_checks++; if (busy_hi !== 0) begin n_fail++; $display("FAIL rst_no_resume_busy: got %0d busy cycles want 0", busy_hi); end
    endtask

    task automatic test_escape;
        logic [7:0] exp[$];
        exp = '{8'h1B, 8'h10, 8'h5A};
        run_stream(1'b0, exp, 1'b0, 200);
        decode(1);
        n_checks++; if (dec_ferr !== 0) begin n_fail++; $display("FAIL esc_framing: got %0d errors want 0", dec_ferr); end
        n_checks++; if (dec_bytes.size() !== 3) begin n_fail++; $display("FAIL esc_count: got %0d bytes want 3", dec_bytes.size()); end
        for (int i = 0; i < 3 && i < dec_bytes.size(); i++) begin
            n_checks++;
            if (dec_bytes[i] !== exp[i]) begin n_fail++; $display("FAIL esc_byte%0d: got %h want %h", i, dec_bytes[i], exp[i]); end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        RESETn        = 1'b0;
        if1.TX_VALID  = 1'b0;
        if1.TX_DATA   = 8'h00;
        if16.TX_VALID = 1'b0;
        if16.TX_DATA  = 8'h00;
        repeat (3) @(negedge clk);
        test_reset();
        RESETn = 1'b1;
        repeat (2) @(negedge clk);
        test_single_byte();
        test_back_to_back();
        test_random_stream();
        test_full_fifo();
        test_divided_baud();
        test_reset_mid_frame();
        test_escape();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
